// File: rtl/line_drawer_stream.sv
// Bresenham line rasteriser with a valid/ready pixel stream.
// Handles all eight octants in endpoint order and flags the final pixel.
module line_drawer_stream #(
    parameter int COORD_W = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    output logic               busy,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               pix_last,
    output logic               done
);

    localparam int EW  = COORD_W + 2;
    localparam int E2W = COORD_W + 3;
    localparam logic [COORD_W-1:0] C_ONE    = {{(COORD_W-1){1'b0}}, 1'b1};
    localparam logic signed [EW-1:0] C_ZERO = {EW{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_DRAW  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state, w_state_nxt;

    logic [COORD_W-1:0] r_x0, r_y0, r_x1, r_y1;
    logic [COORD_W-1:0] r_pix_x, r_pix_y;
    logic signed [EW-1:0] r_dx, r_dy, r_err;
    logic r_sx_neg, r_sy_neg;
    logic r_pix_valid, r_pix_last, r_busy, r_done;

    logic [COORD_W-1:0]    w_dx_abs, w_dy_abs;
    logic signed [EW-1:0]  w_dx_setup, w_dy_setup, w_err_step, w_err_nxt;
    logic signed [E2W-1:0] w_e2, w_dx_ext, w_dy_ext;
    logic                  w_step_x, w_step_y, w_hs, w_latch;
    logic [COORD_W-1:0]    w_nx, w_ny, w_cx_nxt, w_cy_nxt;
    logic                  w_valid_nxt, w_last_nxt, w_busy_nxt, w_done_nxt;

    // Setup arithmetic on the latched endpoints; widened so nothing wraps.
    assign w_dx_abs   = (r_x1 >= r_x0) ? (r_x1 - r_x0) : (r_x0 - r_x1);
    assign w_dy_abs   = (r_y1 >= r_y0) ? (r_y1 - r_y0) : (r_y0 - r_y1);
    assign w_dx_setup = $signed({2'b00, w_dx_abs});
    assign w_dy_setup = C_ZERO - $signed({2'b00, w_dy_abs});

    assign w_e2       = $signed({r_err, 1'b0});
    assign w_dx_ext   = r_dx;
    assign w_dy_ext   = r_dy;
    assign w_step_x   = (w_e2 >= w_dy_ext);
    assign w_step_y   = (w_e2 <= w_dx_ext);
    assign w_err_step = r_err + (w_step_x ? r_dy : C_ZERO) + (w_step_y ? r_dx : C_ZERO);
    assign w_nx       = w_step_x ? (r_sx_neg ? (r_pix_x - C_ONE) : (r_pix_x + C_ONE)) : r_pix_x;
    assign w_ny       = w_step_y ? (r_sy_neg ? (r_pix_y - C_ONE) : (r_pix_y + C_ONE)) : r_pix_y;
    assign w_hs       = r_pix_valid & pix_ready;

    // Next-state and next-output decode; everything holds unless a rule fires.
    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = r_pix_valid;
        w_last_nxt  = r_pix_last;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_cx_nxt    = r_pix_x;
        w_cy_nxt    = r_pix_y;
        w_err_nxt   = r_err;
        w_latch     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_SETUP;
                    w_busy_nxt  = 1'b1;
                    w_latch     = 1'b1;
                end else begin
                    w_busy_nxt  = 1'b0;
                end
            end
            S_SETUP: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_valid_nxt = 1'b0;
                    w_last_nxt  = 1'b0;
                end else begin
                    w_state_nxt = S_DRAW;
                    w_valid_nxt = 1'b1;
                    w_cx_nxt    = r_x0;
                    w_cy_nxt    = r_y0;
                    w_last_nxt  = (r_x0 == r_x1) && (r_y0 == r_y1);
                    w_err_nxt   = w_dx_setup + w_dy_setup;
                end
            end
            S_DRAW: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_valid_nxt = 1'b0;
                    w_last_nxt  = 1'b0;
                end else if (w_hs && r_pix_last) begin
                    w_state_nxt = S_DONE;
                    w_busy_nxt  = 1'b0;
                    w_valid_nxt = 1'b0;
                    w_last_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end else if (w_hs) begin
                    w_cx_nxt    = w_nx;
                    w_cy_nxt    = w_ny;
                    w_err_nxt   = w_err_step;
                    w_last_nxt  = (w_nx == r_x1) && (w_ny == r_y1);
                end else begin
                    w_state_nxt = S_DRAW;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
                w_valid_nxt = 1'b0;
                w_last_nxt  = 1'b0;
            end
        endcase
    end

    // State, registered outputs and per-line working registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_x0        <= {COORD_W{1'b0}};
            r_y0        <= {COORD_W{1'b0}};
            r_x1        <= {COORD_W{1'b0}};
            r_y1        <= {COORD_W{1'b0}};
            r_pix_x     <= {COORD_W{1'b0}};
            r_pix_y     <= {COORD_W{1'b0}};
            r_dx        <= C_ZERO;
            r_dy        <= C_ZERO;
            r_err       <= C_ZERO;
            r_sx_neg    <= 1'b0;
            r_sy_neg    <= 1'b0;
            r_pix_valid <= 1'b0;
            r_pix_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pix_x     <= w_cx_nxt;
            r_pix_y     <= w_cy_nxt;
            r_err       <= w_err_nxt;
            r_pix_valid <= w_valid_nxt;
            r_pix_last  <= w_last_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            if (w_latch) begin
                r_x0 <= x0;
                r_y0 <= y0;
                r_x1 <= x1;
                r_y1 <= y1;
            end
            if (r_state == S_SETUP) begin
                r_dx     <= w_dx_setup;
                r_dy     <= w_dy_setup;
                r_sx_neg <= (r_x0 >= r_x1);
                r_sy_neg <= (r_y0 >= r_y1);
            end
        end
    end

    assign busy      = r_busy;
    assign pix_valid = r_pix_valid;
    assign pix_x     = r_pix_x;
    assign pix_y     = r_pix_y;
    assign pix_last  = r_pix_last;
    assign done      = r_done;

endmodule

// File: tb/tb_line_drawer_stream.sv
// Scoreboard bench for line_drawer_stream: directed lines push expected
// pixels; a negedge monitor pops and compares on every handshake.
module tb_line_drawer_stream;
    localparam int W = 11;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic pix_ready = 1'b0;
    logic [W-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic busy, pix_valid, pix_last, done;
    logic [W-1:0] pix_x, pix_y;

    int n_chk = 0;
    int n_pass = 0;
    int n_done = 0;
    logic [2*W:0] q[$];
    logic [2*W:0] m_exp;

    line_drawer_stream #(.COORD_W(W)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .busy(busy), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_last(pix_last), .done(done)
    );

    always #10 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic px(input int x, input int y, input bit last);
        logic [W-1:0] xv, yv;
        xv = x[W-1:0];
        yv = y[W-1:0];
        q.push_back({xv, yv, last});
    endtask

    // Monitor: compare every accepted pixel against the scoreboard; count done pulses.
    always @(negedge clk) begin
        if (!reset) begin
            if (pix_valid && pix_ready && !abort) begin
                if (q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_pixel: got (%0d,%0d) expected none", pix_x, pix_y);
                end else begin
                    m_exp = q.pop_front();
                    chk("pixel{x,y,last}", {9'd0, pix_x, pix_y, pix_last}, {9'd0, m_exp});
                end
            end
            if (done) n_done++;
        end
    end

    // Issue a start at posedge+1; returns at posedge+1 after the first pixel appears.
    task automatic go(input int ax0, input int ay0, input int ax1, input int ay1);
        x0 = ax0[W-1:0]; y0 = ay0[W-1:0]; x1 = ax1[W-1:0]; y1 = ay1[W-1:0];
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        x0 = W'($urandom); y0 = W'($urandom); x1 = W'($urandom); y1 = W'($urandom);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("no_valid_in_setup", {31'd0, pix_valid}, 32'd0);
        @(posedge clk); #1;
        chk("first_pixel_valid", {31'd0, pix_valid}, 32'd1);
    endtask

    task automatic wait_done(input int exp_cycles);
        int c;
        c = 0;
        while (!done && c < 3000) begin
            @(posedge clk); #1;
            c++;
        end
        chk("done_latency", c, exp_cycles);
        chk("busy_low_in_done", {31'd0, busy}, 32'd0);
        chk("valid_low_in_done", {31'd0, pix_valid}, 32'd0);
        chk("all_pixels_seen", q.size(), 32'd0);
        @(posedge clk); #1;
        chk("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
        chk({nm, "_valid"}, {31'd0, pix_valid}, 32'd0);
        chk({nm, "_last"}, {31'd0, pix_last}, 32'd0);
        chk({nm, "_done"}, {31'd0, done}, 32'd0);
        chk({nm, "_x"}, {21'd0, pix_x}, 32'd0);
        chk({nm, "_y"}, {21'd0, pix_y}, 32'd0);
    endtask

    initial begin
        int d;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset = 1'b0;
        pix_ready = 1'b1;
        @(posedge clk); #1;

        // Shallow right-up
        px(2,6,0); px(3,7,0); px(4,7,0); px(5,8,0); px(6,8,0); px(7,9,0); px(8,9,1);
        go(2, 6, 8, 9);
        wait_done(7);

        // Reversed shallow
        px(8,9,0); px(7,8,0); px(6,8,0); px(5,7,0); px(4,7,0); px(3,6,0); px(2,6,1);
        go(8, 9, 2, 6);
        wait_done(7);

        // Steep positive
        px(6,2,0); px(7,3,0); px(7,4,0); px(8,5,0); px(8,6,0); px(9,7,0); px(9,8,1);
        go(6, 2, 9, 8);
        wait_done(7);

        // Steep negative slope
        px(7,9,0); px(7,8,0); px(8,7,0); px(8,6,0); px(8,5,0);
        px(8,4,0); px(9,3,0); px(9,2,0); px(9,1,1);
        go(7, 9, 9, 1);
        wait_done(9);

        // Single point
        px(5,5,1);
        chk("point_idle", {31'd0, busy}, 32'd0);
        go(5, 5, 5, 5);
        chk("point_last", {31'd0, pix_last}, 32'd1);
        wait_done(1);

        // Backpressure on pixel 2 plus a start pulse while busy
        px(0,0,0); px(1,0,0); px(2,0,0); px(3,0,0); px(4,0,1);
        go(0, 0, 4, 0);
        @(posedge clk); #1;
        chk("stall_target_x", {21'd0, pix_x}, 32'd1);
        pix_ready = 1'b0;
        start = 1'b1;
        x0 = 11'd9; y0 = 11'd9; x1 = 11'd1; y1 = 11'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'b0;
            chk("stall_valid", {31'd0, pix_valid}, 32'd1);
            chk("stall_xy", {10'd0, pix_x, pix_y}, {10'd0, 11'd1, 11'd0});
            chk("stall_last", {31'd0, pix_last}, 32'd0);
        end
        @(posedge clk); #1;
        pix_ready = 1'b1;
        wait_done(4);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("start_while_busy_ignored", {31'd0, busy}, 32'd0);
        end

        // Abort on the third pixel
        px(0,0,0); px(1,1,0);
        go(0, 0, 10, 10);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_third_pixel", {10'd0, pix_x, pix_y}, {10'd0, 11'd2, 11'd2});
        abort = 1'b1;
        d = n_done;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_valid", {31'd0, pix_valid}, 32'd0);
        chk("abort_pixels", q.size(), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_done", n_done, d);
        chk("abort_stays_idle", {31'd0, busy}, 32'd0);

        // Reset mid-line
        for (int i = 0; i <= 10; i++) px(i, i, i == 10);
        go(0, 0, 10, 10);
        repeat (3) @(posedge clk);
        #1;
        chk("pre_reset_valid", {31'd0, pix_valid}, 32'd1);
        reset = 1'b1;
        #1;
        chk_all_zero("midline_reset");
        q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_reset_idle", {31'd0, busy}, 32'd0);
        chk("post_reset_no_valid", {31'd0, pix_valid}, 32'd0);

        // Full-width diagonal
        for (int i = 0; i < 2048; i++) px(i, 2047 - i, i == 2047);
        go(0, 2047, 2047, 0);
        wait_done(2048);

        chk("total_done_pulses", n_done, 32'd7);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
